// File: rtl/spi_pkt_reader.sv
// spi_pkt_reader
// SPI mode-0 master that reads one NUM_BYTES packet from the capture slave.
// Each byte is its own CS-low frame; the slave advances on each CS rising edge,
// so CS is released for CS_GAP cycles between bytes.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (aborts any transfer)
//   start      request a packet read, only looked at in IDLE
//   MISO       serial data from slave, sampled as SCK falls
//   SCK        SPI clock, idle low, half-period CLK_DIV clk cycles
//   CS         chip select, active low
//   MOSI       TX_FILL shifted out MSB first, changes only while SCK is low
//   pkt_out    assembled packet, first received byte in the top byte
//   pkt_valid  one-cycle pulse when pkt_out is updated
//   busy       high from the cycle after start is accepted until back in IDLE
module spi_pkt_reader #(
    parameter int         CLK_DIV   = 4,
    parameter int         NUM_BYTES = 8,
    parameter int         CS_GAP    = 4,
    parameter logic [7:0] TX_FILL   = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   MISO,
    output logic                   SCK,
    output logic                   CS,
    output logic                   MOSI,
    output logic [NUM_BYTES*8-1:0] pkt_out,
    output logic                   pkt_valid,
    output logic                   busy
);

    localparam int             BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [7:0]     DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0]     GAP_LAST  = 8'(CS_GAP - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, GAP, DONE} state_t;

    state_t                      state, state_n;
    logic [7:0]                  div_cnt, div_cnt_n;
    logic [2:0]                  bit_cnt, bit_cnt_n;
    logic [BCW-1:0]              byte_cnt, byte_cnt_n;
    logic [7:0]                  shreg, shreg_n;
    logic [NUM_BYTES-1:0][7:0]   hold, hold_n;
    logic                        sck_n, cs_n, mosi_n, pkt_valid_n, busy_n;
    logic [NUM_BYTES*8-1:0]      pkt_out_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            hold      <= '0;
            SCK       <= 1'b0;
            CS        <= 1'b1;
            MOSI      <= TX_FILL[7];
            pkt_out   <= '0;
            pkt_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_cnt_n;
            bit_cnt   <= bit_cnt_n;
            byte_cnt  <= byte_cnt_n;
            shreg     <= shreg_n;
            hold      <= hold_n;
            SCK       <= sck_n;
            CS        <= cs_n;
            MOSI      <= mosi_n;
            pkt_out   <= pkt_out_n;
            pkt_valid <= pkt_valid_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        div_cnt_n   = div_cnt;
        bit_cnt_n   = bit_cnt;
        byte_cnt_n  = byte_cnt;
        shreg_n     = shreg;
        hold_n      = hold;
        sck_n       = SCK;
        cs_n        = CS;
        mosi_n      = MOSI;
        pkt_out_n   = pkt_out;
        pkt_valid_n = 1'b0;
        busy_n      = busy;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = SETUP;
                    cs_n       = 1'b0;
                    busy_n     = 1'b1;
                    byte_cnt_n = '0;
                    bit_cnt_n  = '0;
                    div_cnt_n  = '0;
                    mosi_n     = TX_FILL[7];
                end
            end
            SETUP: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    sck_n     = 1'b1;
                    state_n   = SCK_HI;
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            SCK_HI: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    sck_n     = 1'b0;
                    shreg_n   = {shreg[6:0], MISO};
                    // 6 - bit_cnt wraps to 7 after the last bit, which leaves
                    // MOSI on TX_FILL[7] ready for the next frame.
                    mosi_n    = TX_FILL[3'(3'd6 - bit_cnt)];
                    state_n   = SCK_LO;
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            SCK_LO: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (bit_cnt != 3'd7) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        sck_n     = 1'b1;
                        state_n   = SCK_HI;
                    end else begin
                        bit_cnt_n = '0;
                        cs_n      = 1'b1;
                        // slot 0 (first byte on the wire) lands in the top byte
                        hold_n[LAST_BYTE - byte_cnt] = shreg;
                        if (byte_cnt != LAST_BYTE) begin
                            byte_cnt_n = byte_cnt + BCW'(1);
                            state_n    = GAP;
                        end else begin
                            state_n    = DONE;
                        end
                    end
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            GAP: begin
                if (div_cnt == GAP_LAST) begin
                    div_cnt_n = '0;
                    cs_n      = 1'b0;
                    state_n   = SETUP;
                end else begin
                    div_cnt_n = div_cnt + 8'd1;
                end
            end
            DONE: begin
                pkt_out_n   = hold;
                pkt_valid_n = 1'b1;
                busy_n      = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_pkt_reader.sv
// Bench for spi_pkt_reader: instance 0 uses default parameters, instance 1 uses
// CLK_DIV=2, CS_GAP=2, TX_FILL=C3. Each has a behavioural mode-0 slave that
// wraps around its 8-byte packet. Expected packets are queued when a read is
// started and popped when pkt_valid pulses; frame/gap/SCK/MOSI timing is
// checked by a negedge monitor.
module tb_spi_pkt_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start;
    logic [1:0]  miso = '0;
    logic [1:0]  sck, cs, mosi, pv, busy;
    logic [63:0] pkt [2];

    logic [63:0] sp [2];
    logic [1:0]  rl, rl_seen = '0;
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    int n_chk = 0, n_fail = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_pkt_reader u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .MISO(miso[0]), .SCK(sck[0]), .CS(cs[0]),
        .MOSI(mosi[0]), .pkt_out(pkt[0]), .pkt_valid(pv[0]), .busy(busy[0])
    );

    spi_pkt_reader #(.CLK_DIV(2), .NUM_BYTES(8), .CS_GAP(2), .TX_FILL(8'hC3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .MISO(miso[1]), .SCK(sck[1]), .CS(cs[1]),
        .MOSI(mosi[1]), .pkt_out(pkt[1]), .pkt_valid(pv[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic slave_bit(input logic [63:0] p, input int b, input int i);
        if (i > 7) return 1'b0;
        return p[63 - b*8 - i];
    endfunction

    // slave + monitor state, owned by the negedge process below
    int         sb [2], sbit [2], low_run [2], gap_run [2], rises [2];
    int         frames [2], frame_rises [2], pv_w [2];
    logic [7:0] mosi_byte [2];
    logic [1:0] cs_q, sck_q, pv_q, busy_q, mosi_q;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int         cdiv, gapc;
            logic [7:0] fill;
            cdiv = (k == 0) ? 4 : 2;
            gapc = (k == 0) ? 4 : 2;
            fill = (k == 0) ? 8'h00 : 8'hC3;

            // slave: advance byte on CS rise, bit on SCK fall
            if (rl[k] != rl_seen[k]) begin
                rl_seen[k] = rl[k];
                sb[k] = 0;
                sbit[k] = 0;
            end else begin
                if (cs[k] && !cs_q[k]) begin sb[k] = (sb[k] + 1) % 8; sbit[k] = 0; end
                if (!cs[k] && cs_q[k]) sbit[k] = 0;
                if (!sck[k] && sck_q[k]) sbit[k]++;
            end
            miso[k] = slave_bit(sp[k], sb[k], sbit[k]);

            if (rst) begin
                low_run[k] = 0; gap_run[k] = 0; rises[k] = 0; frames[k] = 0;
                frame_rises[k] = 0; pv_w[k] = 0; mosi_byte[k] = '0;
            end else begin
                if (!cs[k]) low_run[k]++;
                if (!cs[k] && cs_q[k]) begin
                    frame_rises[k] = 0;
                    if (gap_run[k] > 0) chk("cs_gap_len", 64'(gap_run[k]), 64'(gapc));
                    gap_run[k] = 0;
                end
                if (cs[k] && busy[k]) gap_run[k]++;
                else if (!busy[k]) gap_run[k] = 0;
                if (sck[k] && !sck_q[k]) begin
                    rises[k]++;
                    frame_rises[k]++;
                    mosi_byte[k] = {mosi_byte[k][6:0], mosi[k]};
                end
                if (cs[k] && !cs_q[k]) begin
                    chk("cs_low_len", 64'(low_run[k]), 64'(17 * cdiv));
                    chk("frame_sck_rises", 64'(frame_rises[k]), 64'd8);
                    chk("mosi_bits", 64'(mosi_byte[k]), 64'(fill));
                    frames[k]++;
                    low_run[k] = 0;
                end
                if (mosi[k] !== mosi_q[k]) chk("mosi_chg_sck_low", 64'(sck[k]), 64'd0);
                if (pv[k]) pv_w[k]++;
                if (!pv[k] && pv_q[k]) begin
                    chk("pv_width", 64'(pv_w[k]), 64'd1);
                    pv_w[k] = 0;
                end
                if (!busy[k] && busy_q[k]) chk("busy_fall_with_pv", 64'(pv[k]), 64'd1);
                if (pv[k]) begin
                    chk("pkt_frames", 64'(frames[k]), 64'd8);
                    chk("pkt_sck_rises", 64'(rises[k]), 64'd64);
                    frames[k] = 0;
                    rises[k] = 0;
                    if (k == 0) begin
                        chk("sb0_nonempty", 64'(q0.size() > 0), 64'd1);
                        if (q0.size() > 0) chk("pkt0", pkt[0], q0.pop_front());
                    end else begin
                        chk("sb1_nonempty", 64'(q1.size() > 0), 64'd1);
                        if (q1.size() > 0) chk("pkt1", pkt[1], q1.pop_front());
                    end
                end
            end
            cs_q[k] = cs[k]; sck_q[k] = sck[k]; pv_q[k] = pv[k];
            busy_q[k] = busy[k]; mosi_q[k] = mosi[k];
        end
    end

    task automatic load(input int k, input logic [63:0] v);
        sp[k] = v;
        rl[k] = ~rl[k];
        repeat (2) @(negedge clk);
    endtask

    task automatic push_exp(input int k, input logic [63:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic pulse(input int k);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_pv(input int k, input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pv[k] && n < budget);
        chk({tag, "_pv_seen"}, 64'(pv[k]), 64'd1);
    endtask

    initial begin
        int   n, t1;
        logic drop;
        rst = 1'b1; start = '0; rl = '0;
        sp[0] = '0; sp[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs",    64'(cs),    64'b11);
        chk("rst_sck",   64'(sck),   64'b00);
        chk("rst_busy",  64'(busy),  64'b00);
        chk("rst_pv",    64'(pv),    64'b00);
        chk("rst_mosi",  64'(mosi),  64'b10);
        chk("rst_pkt0",  pkt[0],     64'd0);
        rst = 1'b0;

        // basic read
        load(0, 64'h0123_4567_89AB_CDEF);
        push_exp(0, 64'h0123_4567_89AB_CDEF);
        pulse(0);
        wait_pv(0, 3000, "t1");

        // repeated start pulses during a read are ignored
        load(0, 64'h1122_3344_5566_7788);
        push_exp(0, 64'h1122_3344_5566_7788);
        pulse(0);
        n = 0; drop = 1'b0;
        while (!pv[0] && n < 3000) begin
            if (!busy[0]) drop = 1'b1;
            start[0] = (n % 40 == 0);
            @(negedge clk);
            n++;
        end
        start[0] = 1'b0;
        chk("t2_pv_seen", 64'(pv[0]), 64'd1);
        chk("t2_busy_held", 64'(drop), 64'd0);
        repeat (30) @(negedge clk);
        chk("t2_single_read", 64'(busy[0]), 64'd0);

        // reset in byte 3, bit 4 aborts with no packet
        load(0, 64'h1357_9BDF_2468_ACE0);
        pulse(0);
        n = 0;
        while (rises[0] != 29 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t3_reached_bit4", 64'(rises[0]), 64'd29);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_cs",   64'(cs[0]),   64'd1);
        chk("t3_sck",  64'(sck[0]),  64'd0);
        chk("t3_busy", 64'(busy[0]), 64'd0);
        chk("t3_pv",   64'(pv[0]),   64'd0);
        chk("t3_pkt",  pkt[0],       64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load(0, 64'hDEAD_BEEF_CAFE_F00D);
        push_exp(0, 64'hDEAD_BEEF_CAFE_F00D);
        pulse(0);
        wait_pv(0, 3000, "t3");

        // start held high: back-to-back reads
        load(0, 64'hA55A_A55A_A55A_A55A);
        push_exp(0, 64'hA55A_A55A_A55A_A55A);
        push_exp(0, 64'hA55A_A55A_A55A_A55A);
        start[0] = 1'b1;
        wait_pv(0, 3000, "t4a");
        t1 = cyc;
        chk("t4_busy_low", 64'(busy[0]), 64'd0);
        @(negedge clk);
        chk("t4_restart", 64'(busy[0]), 64'd1);
        wait_pv(0, 3000, "t4b");
        start[0] = 1'b0;
        // IDLE + 8 frames of 68 + 7 gaps of 4 + DONE
        chk("t4_period", 64'(cyc - t1), 64'd574);
        repeat (20) @(negedge clk);
        chk("t4_stopped", 64'(busy[0]), 64'd0);

        // fast divider / short gap / non-zero fill
        load(1, 64'hFFFF_0000_FFFF_0001);
        push_exp(1, 64'hFFFF_0000_FFFF_0001);
        pulse(1);
        wait_pv(1, 3000, "t5");

        repeat (5) @(negedge clk);
        chk("sb0_drained", 64'(q0.size()), 64'd0);
        chk("sb1_drained", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
